// File: rtl/rst_seq_pkg.sv
// Shared definitions for the reset sequencer.
// Contents:
//   seq_state_e : FSM state encoding, also exported on the debug `state` port
//   LOSS_W      : width of the saturating lock-loss counter
//   sat_inc     : saturating increment used for the lock-loss counter
package rst_seq_pkg;

  typedef enum logic [1:0] {
    ST_WAIT_LOCK = 2'd0,
    ST_FILTER    = 2'd1,
    ST_RELEASE   = 2'd2,
    ST_RUN       = 2'd3
  } seq_state_e;

  localparam int LOSS_W = 8;

  // Holds at all-ones instead of wrapping.
  function automatic logic [LOSS_W-1:0] sat_inc(input logic [LOSS_W-1:0] v);
    return (v == '1) ? v : v + LOSS_W'(1);
  endfunction

endpackage

// File: rtl/reset_sequencer_if.sv
// Bundle of the signals exchanged between the reset sequencer and its users.
// Signals:
//   locked   : MMCM LOCKED status, asynchronous to clk
//   rst_out  : per-stage active-high resets, bit 0 releases first
//   ready    : high while every stage is released
//   loss_cnt : saturating count of lock losses seen in RELEASE or RUN
//   state    : current FSM state for debug/LEDs
// Modports: master = the sequencer, slave = the consumer / clock generator side.
interface reset_sequencer_if #(
  parameter int NUM_STAGES = 3
);
  import rst_seq_pkg::*;

  logic                  locked;
  logic [NUM_STAGES-1:0] rst_out;
  logic                  ready;
  logic [LOSS_W-1:0]     loss_cnt;
  logic [1:0]            state;

  modport master (input locked, output rst_out, ready, loss_cnt, state);
  modport slave  (output locked, input rst_out, ready, loss_cnt, state);

endinterface

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer with synchronous clear.
// Ports:
//   clk : destination clock
//   clr : synchronous active-high clear of both flops
//   d   : asynchronous input
//   q   : synchronized output, two clk edges of latency
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value; blocking here would collapse the two stages into one.
  always_ff @(posedge clk) begin
    if (clr) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/reset_sequencer.sv
// Turns the MMCM's asynchronous LOCKED into ordered, synchronous, active-high
// resets. LOCKED is synchronized, filtered for LOCK_FILT cycles, then the
// stages release one at a time STAGE_GAP cycles apart. Losing lock re-asserts
// every stage at once and bumps a saturating loss counter.
// Ports:
//   clk : 100 MHz MMCM output clock, the only clock
//   rst : synchronous active-high reset, overrides everything
//   seq : master side of reset_sequencer_if (locked in; rst_out, ready,
//         loss_cnt, state out). All outputs are registered.
module reset_sequencer
  import rst_seq_pkg::*;
#(
  parameter int NUM_STAGES = 3,
  parameter int LOCK_FILT  = 16,
  parameter int STAGE_GAP  = 8
) (
  input logic              clk,
  input logic              rst,
  reset_sequencer_if.master seq
);

  localparam int MAX_CNT = (LOCK_FILT > STAGE_GAP) ? LOCK_FILT : STAGE_GAP;
  localparam int CW      = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;
  localparam int SW      = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

  localparam logic [CW-1:0] FILT_LAST  = CW'(LOCK_FILT - 1);
  localparam logic [CW-1:0] GAP_LAST   = CW'(STAGE_GAP - 1);
  localparam logic [SW-1:0] STAGE_LAST = SW'(NUM_STAGES - 1);

  seq_state_e            state_q;
  logic [CW-1:0]         cnt;
  logic [SW-1:0]         stage;
  logic [NUM_STAGES-1:0] rst_q;
  logic                  ready_q;
  logic [LOSS_W-1:0]     loss_q;
  logic                  locked_s;

  // Only this synchronizer samples the raw LOCKED input.
  sync_2ff #(.WIDTH(1)) u_sync (
    .clk (clk),
    .clr (rst),
    .d   (seq.locked),
    .q   (locked_s)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_WAIT_LOCK;
      rst_q   <= '1;
      ready_q <= 1'b0;
      cnt     <= '0;
      stage   <= '0;
      loss_q  <= '0;
    end else begin
      unique case (state_q)
        ST_WAIT_LOCK: begin
          rst_q   <= '1;
          ready_q <= 1'b0;
          if (locked_s) begin
            state_q <= ST_FILTER;
            cnt     <= '0;
          end
        end

        // A drop here is treated as a glitch and is not counted as a loss.
        ST_FILTER: begin
          if (!locked_s) begin
            state_q <= ST_WAIT_LOCK;
          end else if (cnt == FILT_LAST) begin
            state_q <= ST_RELEASE;
            cnt     <= '0;
            stage   <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        // Lock loss is tested first so it wins over a coincident release.
        ST_RELEASE: begin
          if (!locked_s) begin
            rst_q   <= '1;
            loss_q  <= sat_inc(loss_q);
            state_q <= ST_WAIT_LOCK;
          end else if (cnt == GAP_LAST) begin
            rst_q[stage] <= 1'b0;
            cnt          <= '0;
            if (stage == STAGE_LAST) begin
              state_q <= ST_RUN;
              ready_q <= 1'b1;
            end else begin
              stage <= stage + SW'(1);
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        ST_RUN: begin
          rst_q   <= '0;
          ready_q <= 1'b1;
          if (!locked_s) begin
            rst_q   <= '1;
            ready_q <= 1'b0;
            loss_q  <= sat_inc(loss_q);
            state_q <= ST_WAIT_LOCK;
          end
        end

        default: state_q <= ST_WAIT_LOCK;
      endcase
    end
  end

  assign seq.rst_out  = rst_q;
  assign seq.ready    = ready_q;
  assign seq.loss_cnt = loss_q;
  assign seq.state    = state_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Self-checking bench for reset_sequencer. A timeline model tracks how many
// consecutive edges the sequencer has seen a synchronized lock and derives
// every output from that run length; a negedge process compares the DUT to
// it each cycle, and directed scenarios pin literal edge timings.
module tb_reset_sequencer;
  import rst_seq_pkg::*;

  localparam int N = 3;
  localparam int L = 16;
  localparam int G = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  reset_sequencer_if #(.NUM_STAGES(N)) sif ();

  reset_sequencer #(.NUM_STAGES(N), .LOCK_FILT(L), .STAGE_GAP(G)) dut (
    .clk (clk),
    .rst (rst),
    .seq (sif)
  );

  int vectors = 0;
  int fails   = 0;
  bit chk_en  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Model: n = consecutive edges at which the FSM observed synchronized lock.
  int n      = 0;
  int m_loss = 0;
  bit s1     = 1'b0;
  bit s2     = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      n = 0; m_loss = 0; s1 = 1'b0; s2 = 1'b0;
    end else begin
      if (s2) begin
        if (n < 1000000) n++;
      end else begin
        if (n >= 1 + L) m_loss = (m_loss < 255) ? m_loss + 1 : 255;
        n = 0;
      end
      s2 = s1;
      s1 = sif.locked;
    end
  end

  function automatic logic [N-1:0] exp_rst(input int k_n);
    logic [N-1:0] r;
    for (int k = 0; k < N; k++) r[k] = !(k_n >= 1 + L + G * (k + 1));
    return r;
  endfunction

  function automatic logic [1:0] exp_state(input int k_n);
    if (k_n == 0)               return 2'd0;
    if (k_n <= L)               return 2'd1;
    if (k_n < 1 + L + G * N)    return 2'd2;
    return 2'd3;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      check("rst_out",  32'(sif.rst_out),  32'(exp_rst(n)));
      check("ready",    32'(sif.ready),    32'(n >= 1 + L + G * N));
      check("state",    32'(sif.state),    32'(exp_state(n)));
      check("loss_cnt", 32'(sif.loss_cnt), 32'(m_loss));
    end
  end

  task automatic step(input int k);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; sif.locked = 1'b0;
    step(2);
    rst = 1'b0;
    step(2);
  endtask

  initial begin
    rst = 1'b1;
    sif.locked = 1'b0;

    // Power-up: rst held 4 cycles with locked low.
    for (int i = 0; i < 4; i++) begin
      step(1);
      chk_en = 1'b1;
      check("pwr_rst_out", 32'(sif.rst_out), 32'h7);
      check("pwr_ready",   32'(sif.ready),   32'h0);
      check("pwr_state",   32'(sif.state),   32'h0);
    end
    rst = 1'b0;
    step(2);

    // Clean lock: locked sampled high at edge 0.
    sif.locked = 1'b1;
    step(26); check("clean_e25", 32'(sif.rst_out), 32'h7);
    step(1);  check("clean_e26", 32'(sif.rst_out), 32'h6);
    step(7);  check("clean_e33", 32'(sif.rst_out), 32'h6);
    step(1);  check("clean_e34", 32'(sif.rst_out), 32'h4);
    step(7);  check("clean_e41", 32'(sif.rst_out), 32'h4);
              check("clean_rdy41", 32'(sif.ready), 32'h0);
    step(1);  check("clean_e42", 32'(sif.rst_out), 32'h0);
              check("clean_rdy42", 32'(sif.ready), 32'h1);
              check("clean_state", 32'(sif.state), 32'h3);
              check("clean_loss",  32'(sif.loss_cnt), 32'h0);
    step(5);

    // Loss in RUN.
    sif.locked = 1'b0;
    step(2);  check("run_loss_e1", 32'(sif.rst_out), 32'h0);
              check("run_loss_rdy1", 32'(sif.ready), 32'h1);
    step(1);  check("run_loss_e2", 32'(sif.rst_out), 32'h7);
              check("run_loss_rdy2", 32'(sif.ready), 32'h0);
              check("run_loss_cnt", 32'(sif.loss_cnt), 32'h1);
    step(3);
    sif.locked = 1'b1;
    step(27); check("relock_e26", 32'(sif.rst_out), 32'h6);
    step(16); check("relock_e42", 32'(sif.rst_out), 32'h0);
              check("relock_rdy", 32'(sif.ready), 32'h1);
              check("relock_loss", 32'(sif.loss_cnt), 32'h1);

    // Loss sampled on the edge that would release stage 1.
    do_reset();
    sif.locked = 1'b1;
    step(32); check("rel_edge_e31", 32'(sif.rst_out), 32'h6);
    sif.locked = 1'b0;
    step(2);  check("rel_edge_e33", 32'(sif.rst_out), 32'h6);
    step(1);  check("rel_edge_e34", 32'(sif.rst_out), 32'h7);
              check("rel_edge_loss", 32'(sif.loss_cnt), 32'h1);
              check("rel_edge_state", 32'(sif.state), 32'h0);

    // Filter glitch: 3-cycle drop during FILTER.
    do_reset();
    sif.locked = 1'b1;
    step(10); check("glitch_filter", 32'(sif.state), 32'h1);
    sif.locked = 1'b0;
    step(3);  check("glitch_wait", 32'(sif.state), 32'h0);
              check("glitch_loss", 32'(sif.loss_cnt), 32'h0);
    sif.locked = 1'b1;
    step(26); check("glitch_e25", 32'(sif.rst_out), 32'h7);
    step(1);  check("glitch_e26", 32'(sif.rst_out), 32'h6);
              check("glitch_loss2", 32'(sif.loss_cnt), 32'h0);

    // Randomized lock behaviour with occasional resets.
    for (int i = 0; i < 60; i++) begin
      sif.locked = 1'b1;
      step($urandom_range(1, 60));
      sif.locked = 1'b0;
      step($urandom_range(1, 8));
      if ($urandom_range(0, 9) == 0) begin
        rst = 1'b1;
        step(1);
        rst = 1'b0;
      end
    end

    // Saturation: 300 losses, each after reaching RELEASE.
    do_reset();
    for (int i = 0; i < 300; i++) begin
      sif.locked = 1'b1;
      step(22);
      sif.locked = 1'b0;
      step(4);
    end
    check("sat_loss", 32'(sif.loss_cnt), 32'hff);

    // Reset asserted during RELEASE.
    sif.locked = 1'b1;
    step(24);
    check("mid_release", 32'(sif.state), 32'h2);
    rst = 1'b1;
    step(1);
    check("mid_rst_loss",  32'(sif.loss_cnt), 32'h0);
    check("mid_rst_state", 32'(sif.state),    32'h0);
    check("mid_rst_out",   32'(sif.rst_out),  32'h7);
    rst = 1'b0;
    step(3);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
